// File: rtl/collision_detector.sv
`default_nettype none

`ifndef GAME_INIT
`define GAME_INIT    2'd0
`endif
`ifndef GAME_RUNNING
`define GAME_RUNNING 2'd1
`endif
`ifndef GAME_FAILED
`define GAME_FAILED  2'd2
`endif
`ifndef GameState
`define GameState logic [1:0]
`endif
`ifndef PosX
`define PosX logic [9:0]
`endif
`ifndef PosY
`define PosY logic [9:0]
`endif

// ============================================================================
// Module   : collision_detector
// Purpose  : Counts bird/pillar overlap pixels per frame and, at each frame
//            boundary, declares a sticky pillar / ground / ceiling hit.
// Revision : 1.0 - initial release
// ============================================================================
module collision_detector #(
    parameter int SCREEN_W      = 640,
    parameter int SCREEN_H      = 480,
    parameter int GROUND_Y      = 400,
    parameter int BIRD_HEIGHT   = 20,
    parameter int HIT_THRESHOLD = 4,
    parameter int GRACE_FRAMES  = 30
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       frame_clk,
    input  `GameState  state,
    input  `PosX       x,
    input  `PosY       y,
    input  logic       bird_valid,
    input  logic       pillar_valid,
    input  `PosY       bird_y,
    output logic       hit,
    output logic       hit_pulse,
    output logic [1:0] hit_kind,
    output logic [9:0] overlap_count
);

    localparam logic [10:0] c_screen_w  = 11'(SCREEN_W);
    localparam logic [10:0] c_screen_h  = 11'(SCREEN_H);
    localparam logic [10:0] c_ground_y  = 11'(GROUND_Y);
    localparam logic [10:0] c_bird_h    = 11'(BIRD_HEIGHT);
    localparam logic [9:0]  c_threshold = 10'(HIT_THRESHOLD);
    localparam logic [8:0]  c_grace     = 9'(GRACE_FRAMES);
    localparam logic        c_no_grace  = (GRACE_FRAMES == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GRACE  = 2'd1,
        S_DETECT = 2'd2,
        S_HIT    = 2'd3
    } det_state_t;

    det_state_t  r_fsm;
    logic [9:0]  r_x_d, r_y_d, r_x_dd, r_y_dd;
    logic [9:0]  r_cnt;
    logic [7:0]  r_grace_cnt;
    logic        r_fs1, r_fs2, r_fs3;
    logic        r_sv1, r_sv2, r_armed;
    logic        w_frame_tick;
    logic        w_advance;
    logic        w_inc;
    logic [10:0] w_bird_bottom;
    logic [1:0]  w_cause;

    // Synchronise frame_clk; arm the edge detector only once a real low has
    // been sampled, so a reset released while frame_clk is high cannot tick.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fs1   <= 1'b0;
            r_fs2   <= 1'b0;
            r_fs3   <= 1'b0;
            r_sv1   <= 1'b0;
            r_sv2   <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_fs1   <= frame_clk;
            r_fs2   <= r_fs1;
            r_fs3   <= r_fs2;
            r_sv1   <= 1'b1;
            r_sv2   <= r_sv1;
            r_armed <= r_armed | (r_sv2 & ~r_fs2);
        end
    end

    assign w_frame_tick = r_armed & r_fs2 & ~r_fs3;

    // Delay scan position to line up with the registered valid flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x_d  <= '0;
            r_y_d  <= '0;
            r_x_dd <= '0;
            r_y_dd <= '0;
        end else begin
            r_x_d  <= x;
            r_y_d  <= y;
            r_x_dd <= r_x_d;
            r_y_dd <= r_y_d;
        end
    end

    assign w_advance = ({r_x_d, r_y_d} != {r_x_dd, r_y_dd});
    assign w_inc     = w_advance & bird_valid & pillar_valid &
                       ({1'b0, r_x_d} < c_screen_w) & ({1'b0, r_y_d} < c_screen_h);

    // Saturating per-frame overlap counter; the frame tick snapshots and clears it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt         <= '0;
            overlap_count <= '0;
        end else if (w_frame_tick) begin
            overlap_count <= r_cnt;
            r_cnt         <= '0;
        end else if (w_inc && (r_cnt != 10'h3FF)) begin
            r_cnt <= r_cnt + 10'd1;
        end
    end

    // Hit cause for the frame just finished, highest priority first.
    assign w_bird_bottom = {1'b0, bird_y} + c_bird_h;

    always_comb begin
        w_cause = 2'd0;
        if (r_cnt >= c_threshold)
            w_cause = 2'd1;
        else if (w_bird_bottom > c_ground_y)
            w_cause = 2'd2;
        else if (bird_y == 10'd0)
            w_cause = 2'd3;
    end

    // Detection FSM with registered hit outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fsm       <= S_IDLE;
            r_grace_cnt <= '0;
            hit         <= 1'b0;
            hit_pulse   <= 1'b0;
            hit_kind    <= 2'd0;
        end else begin
            hit_pulse <= 1'b0;
            if (state == `GAME_INIT) begin
                r_fsm       <= S_IDLE;
                r_grace_cnt <= '0;
                hit         <= 1'b0;
                hit_kind    <= 2'd0;
            end else begin
                case (r_fsm)
                    S_IDLE: begin
                        if (state == `GAME_RUNNING)
                            r_fsm <= S_GRACE;
                    end
                    S_GRACE: begin
                        if (state == `GAME_FAILED) begin
                            r_fsm     <= S_HIT;
                            hit       <= 1'b1;
                            hit_pulse <= 1'b1;
                        end else if (c_no_grace) begin
                            r_fsm <= S_DETECT;
                        end else if (w_frame_tick) begin
                            r_grace_cnt <= r_grace_cnt + 8'd1;
                            if (({1'b0, r_grace_cnt} + 9'd1) == c_grace)
                                r_fsm <= S_DETECT;
                        end
                    end
                    S_DETECT: begin
                        if (w_frame_tick && (w_cause != 2'd0)) begin
                            r_fsm     <= S_HIT;
                            hit       <= 1'b1;
                            hit_pulse <= 1'b1;
                            hit_kind  <= w_cause;
                        end else if (state == `GAME_FAILED) begin
                            r_fsm     <= S_HIT;
                            hit       <= 1'b1;
                            hit_pulse <= 1'b1;
                        end
                    end
                    default: begin
                        r_fsm <= S_HIT;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none

`ifndef GAME_INIT
`define GAME_INIT    2'd0
`endif
`ifndef GAME_RUNNING
`define GAME_RUNNING 2'd1
`endif
`ifndef GAME_FAILED
`define GAME_FAILED  2'd2
`endif

// ============================================================================
// Module   : tb_collision_detector
// Purpose  : Directed self-checking bench for collision_detector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_collision_detector;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       frame_clk = 1'b0;
    logic [1:0] state = `GAME_INIT;
    logic [9:0] x = '0;
    logic [9:0] y = '0;
    logic       bird_valid = 1'b0;
    logic       pillar_valid = 1'b0;
    logic [9:0] bird_y = 10'd100;
    logic       hit;
    logic       hit_pulse;
    logic [1:0] hit_kind;
    logic [9:0] overlap_count;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int p0 = 0;
    int pad_x = 0;
    logic pb = 1'b0;
    logic pp = 1'b0;

    collision_detector #(
        .SCREEN_W(640), .SCREEN_H(480), .GROUND_Y(400), .BIRD_HEIGHT(20),
        .HIT_THRESHOLD(4), .GRACE_FRAMES(2)
    ) dut (
        .clk(clk), .rstn(rstn), .frame_clk(frame_clk), .state(state),
        .x(x), .y(y), .bird_valid(bird_valid), .pillar_valid(pillar_valid),
        .bird_y(bird_y), .hit(hit), .hit_pulse(hit_pulse), .hit_kind(hit_kind),
        .overlap_count(overlap_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (hit_pulse) pulses <= pulses + 1;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clk of scan: new position now, valids for the previous pixel now.
    task automatic cyc(input int nx, input int ny, input logic b, input logic p);
        @(posedge clk); #1;
        x = 10'(nx);
        y = 10'(ny);
        bird_valid = pb;
        pillar_valid = pp;
        pb = b;
        pp = p;
    endtask

    task automatic pad(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(100 + (pad_x % 400), 200, 1'b0, 1'b0);
            pad_x++;
        end
    endtask

    // A frame: nov overlap pixels held 'hold' clks each, then a frame_clk pulse.
    task automatic frame(input int nov, input int hold, input int xbase);
        for (int i = 0; i < nov; i++)
            for (int h = 0; h < hold; h++)
                cyc(xbase + i, 10, 1'b1, 1'b1);
        pad(4);
        frame_clk = 1'b1;
        pad(4);
        frame_clk = 1'b0;
        pad(4);
    endtask

    task automatic restart();
        state = `GAME_INIT;
        pad(2);
        state = `GAME_RUNNING;
        pad(2);
    endtask

    initial begin
        pad(4);
        chk("reset_hit", int'(hit), 0);
        chk("reset_pulse", int'(hit_pulse), 0);
        chk("reset_kind", int'(hit_kind), 0);
        chk("reset_ovl", int'(overlap_count), 0);
        rstn = 1'b1;
        pad(4);

        // Pillar hit in frame 3 after two grace frames
        p0 = pulses;
        state = `GAME_RUNNING;
        frame(0, 1, 0);
        chk("pillar_f1_hit", int'(hit), 0);
        frame(0, 1, 0);
        chk("pillar_f2_hit", int'(hit), 0);
        frame(5, 1, 0);
        chk("pillar_hit", int'(hit), 1);
        chk("pillar_kind", int'(hit_kind), 1);
        chk("pillar_ovl", int'(overlap_count), 5);
        chk("pillar_pulses", pulses - p0, 1);

        // Recovery to INIT one clk later
        state = `GAME_INIT;
        cyc(0, 300, 1'b0, 1'b0);
        chk("init_hit", int'(hit), 0);
        chk("init_kind", int'(hit_kind), 0);

        // Below threshold for ten detect frames
        state = `GAME_RUNNING;
        pad(2);
        frame(0, 1, 0);
        frame(0, 1, 0);
        for (int f = 0; f < 10; f++) begin
            frame(3, 1, 0);
            chk("below_ovl", int'(overlap_count), 3);
            chk("below_hit", int'(hit), 0);
        end

        // Pixel held 4 clks counts once
        frame(2, 4, 0);
        chk("ratio_ovl", int'(overlap_count), 2);
        // Off-screen columns are ignored
        frame(5, 1, 700);
        chk("offscr_ovl", int'(overlap_count), 0);
        chk("offscr_hit", int'(hit), 0);

        // Ground boundary: 380 safe, 381 hits
        bird_y = 10'd380;
        frame(0, 1, 0);
        chk("ground380_hit", int'(hit), 0);
        p0 = pulses;
        bird_y = 10'd381;
        frame(0, 1, 0);
        chk("ground381_hit", int'(hit), 1);
        chk("ground381_kind", int'(hit_kind), 2);
        chk("ground_pulses", pulses - p0, 1);

        // Pillar takes priority over ground
        restart();
        frame(0, 1, 0);
        frame(0, 1, 0);
        frame(6, 1, 0);
        chk("prio_kind", int'(hit_kind), 1);
        chk("prio_ovl", int'(overlap_count), 6);

        // Ceiling
        bird_y = 10'd0;
        restart();
        frame(0, 1, 0);
        frame(0, 1, 0);
        frame(0, 1, 0);
        chk("ceil_hit", int'(hit), 1);
        chk("ceil_kind", int'(hit_kind), 3);

        // Grace frames suppress a large overlap
        bird_y = 10'd100;
        restart();
        frame(50, 1, 0);
        chk("grace1_hit", int'(hit), 0);
        chk("grace1_ovl", int'(overlap_count), 50);
        frame(50, 1, 0);
        chk("grace2_hit", int'(hit), 0);
        frame(50, 1, 0);
        chk("grace_det_hit", int'(hit), 1);
        chk("grace_det_kind", int'(hit_kind), 1);

        // External GAME_FAILED while detecting: hit with kind 0
        restart();
        frame(0, 1, 0);
        frame(0, 1, 0);
        frame(2, 1, 0);
        chk("failed_pre_hit", int'(hit), 0);
        p0 = pulses;
        state = `GAME_FAILED;
        pad(2);
        chk("failed_hit", int'(hit), 1);
        chk("failed_kind", int'(hit_kind), 0);
        chk("failed_pulses", pulses - p0, 1);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 3; i++) cyc(i, 20, 1'b1, 1'b1);
        @(posedge clk); #3;
        rstn = 1'b0;
        #1;
        chk("areset_hit", int'(hit), 0);
        chk("areset_kind", int'(hit_kind), 0);
        chk("areset_ovl", int'(overlap_count), 0);
        chk("areset_pulse", int'(hit_pulse), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        state = `GAME_INIT;
        pb = 1'b0;
        pp = 1'b0;
        pad(2);
        for (int i = 0; i < 3; i++) cyc(i, 30, 1'b1, 1'b1);
        pad(10);
        chk("areset_notick_ovl", int'(overlap_count), 0);
        frame(0, 1, 0);
        chk("areset_tick_ovl", int'(overlap_count), 3);
        chk("areset_tick_hit", int'(hit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
